// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: shared FSM state encoding and BCD digit width.
package bin_to_bcd_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    localparam int BCD_W = 4;
endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// bin_to_bcd_seq_add3: double-dabble digit correction, adds 3 when the digit is 5 or more.
module bin_to_bcd_seq_add3 (
    input  logic [3:0] i_d,
    output logic [3:0] o_d
);
    assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one input bit per clock.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int W      = 5,
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [W-1:0]            bin,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd
);
    localparam int SW = BCD_W * DIGITS;
    localparam int CW = $clog2(W + 1);

    if (10 ** DIGITS <= 2 ** W - 1) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS=%0d too small for W=%0d", DIGITS, W);
    end

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_scr, r_bcd, w_adj, w_scr;
    logic [W-1:0]  r_sh;
    logic          r_done;

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bin_to_bcd_seq_add3 u_add3 (
            .i_d(r_scr[d*BCD_W +: BCD_W]),
            .o_d(w_adj[d*BCD_W +: BCD_W])
        );
    end

    // The top digit's carry-out is always 0 when DIGITS covers W, so it is dropped.
    assign w_scr = SW'({w_adj, r_sh[W-1]});

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && start)
            w_next = SHIFT;
        else if (r_state == SHIFT && r_cnt == CW'(1))
            w_next = DONE;
        else if (r_state == DONE)
            w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_scr   <= '0;
            r_sh    <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (r_state == IDLE && start) begin
                r_sh  <= bin;
                r_scr <= '0;
                r_cnt <= CW'(W);
            end else if (r_state == SHIFT) begin
                r_scr <= w_scr;
                r_sh  <= r_sh << 1;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_bcd  <= w_scr;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign bcd  = r_bcd;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: checks a W=5/DIGITS=2 and a W=8/DIGITS=3 converter against a cycle-count model.
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  st = '0;
    logic [7:0]  bn [2];
    logic        busy_a, done_a, busy_b, done_b;
    logic [7:0]  bcd_a;
    logic [11:0] bcd_b;
    int          tests = 0;
    int          fails = 0;
    int          m_left [2] = '{0, 0};
    int          m_val [2] = '{0, 0};
    logic [11:0] m_bcd [2] = '{12'h0, 12'h0};
    int          done_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.W(5), .DIGITS(2)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .bin(bn[0][4:0]),
        .busy(busy_a), .done(done_a), .bcd(bcd_a)
    );

    bin_to_bcd_seq #(.W(8), .DIGITS(3)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .bin(bn[1]),
        .busy(busy_b), .done(done_b), .bcd(bcd_b)
    );

    function automatic logic [11:0] to_bcd(int v);
        logic [11:0] r = '0;
        for (int d = 0; d < 3; d++) r[4*d +: 4] = 4'((v / (10 ** d)) % 10);
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a conversion occupies W+1 cycles after acceptance; the result appears in the last one.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_left[k] = 0;
                m_bcd[k]  = '0;
            end else if (m_left[k] == 0) begin
                if (st[k]) begin
                    m_left[k] = (k ? 8 : 5) + 1;
                    m_val[k]  = int'(k ? bn[k] : {3'b0, bn[k][4:0]});
                end
            end else begin
                m_left[k]--;
                if (m_left[k] == 1) m_bcd[k] = to_bcd(m_val[k]);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy_a", 32'(busy_a), 32'(m_left[0] != 0));
        chk("done_a", 32'(done_a), 32'(m_left[0] == 1));
        chk("bcd_a",  32'(bcd_a),  32'(m_bcd[0]));
        chk("busy_b", 32'(busy_b), 32'(m_left[1] != 0));
        chk("done_b", 32'(done_b), 32'(m_left[1] == 1));
        chk("bcd_b",  32'(bcd_b),  32'(m_bcd[1]));
        if (done_a) done_cnt[0]++;
        if (done_b) done_cnt[1]++;
    end

    task automatic conv(int k, int v, logic [11:0] exp, int lat);
        int n = 0;
        st[k] = 1'b1;
        bn[k] = 8'(v);
        @(posedge clk);
        #1 st[k] = 1'b0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (k ? done_b : done_a) break;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("lit_bcd", 32'(k ? bcd_b : {4'h0, bcd_a}), 32'(exp));
        @(posedge clk);
        #1 chk("idle_after", 32'(k ? busy_b : busy_a), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        bn[0] = '0;
        bn[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 32'(0));
        chk("rst_done", 32'(done_a), 32'(0));
        chk("rst_bcd_a", 32'(bcd_a), 32'(0));
        chk("rst_bcd_b", 32'(bcd_b), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        conv(0, 0, 12'h000, 6);
        conv(0, 31, 12'h031, 6);
        conv(0, 10, 12'h010, 6);
        conv(0, 9, 12'h009, 6);
        conv(1, 255, 12'h255, 9);
        conv(1, 100, 12'h100, 9);
        // start while busy is ignored
        st[0] = 1'b1;
        bn[0] = 8'd7;
        @(posedge clk);
        #1 st[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        st[0] = 1'b1;
        bn[0] = 8'd20;
        @(posedge clk);
        #1 st[0] = 1'b0;
        c0 = done_cnt[0];
        repeat (10) @(posedge clk);
        #1;
        chk("rej_dones", 32'(done_cnt[0] - c0), 32'(1));
        chk("rej_bcd", 32'(bcd_a), 32'h07);
        conv(0, 20, 12'h020, 6);
        // reset in the middle of a conversion
        st[0] = 1'b1;
        bn[0] = 8'd31;
        @(posedge clk);
        #1 st[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy_a), 32'(0));
        chk("mid_rst_done", 32'(done_a), 32'(0));
        chk("mid_rst_bcd", 32'(bcd_a), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        c0 = done_cnt[0];
        repeat (10) @(posedge clk);
        #1 chk("mid_rst_nodone", 32'(done_cnt[0] - c0), 32'(0));
        conv(0, 5, 12'h005, 6);
        // start held high, bin stepped once per conversion
        c0 = done_cnt[0];
        st[0] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bn[0] = 8'(i);
            repeat (7) @(posedge clk);
            #1;
        end
        st[0] = 1'b0;
        chk("b2b_dones", 32'(done_cnt[0] - c0), 32'(32));
        chk("b2b_last", 32'(bcd_a), 32'h31);
        // random traffic; bin on the narrow unit is an adder sum of two 4-bit operands
        for (int i = 0; i < 400; i++) begin
            st[0] = 1'($urandom_range(0, 1));
            bn[0] = 8'($urandom_range(0, 15) + $urandom_range(0, 15));
            st[1] = 1'($urandom_range(0, 1));
            bn[1] = 8'($urandom);
            rst   = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
        end
        st  = '0;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
